// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// controller for the MEM stage.
//
// State table
//   state | meaning
//   IDLE  | serve hits combinationally; a miss or store starts a transaction
//   FILL  | read request to memory outstanding, waiting for mem_ready
//   WRITE | write request to memory outstanding, waiting for mem_ready
//   DONE  | one unfrozen cycle so the pipeline retires the held request
//
// Ports
//   clk, rst_b          clock (rising edge), async active-low reset
//   cache_en            MEM-stage access valid
//   mem_write           1 = store, 0 = load
//   is_LB_SB            1 = byte access, 0 = word access
//   alu_result          effective byte address
//   rt_data             store data
//   cache_data_out      4 bytes of the indexed line (element k = bits [8k+7:8k])
//   mem_block           byte offset alu_result[1:0]
//   freeze              stall request to all pipeline registers
//   mem_addr            word-aligned memory address
//   mem_rd_req/wr_req   memory read / write request
//   mem_wdata/mem_wstrb memory write data / byte enables
//   mem_rdata/mem_ready memory read data / one-cycle completion pulse

module dcache_ctrl #(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        cache_en,
    input  logic        mem_write,
    input  logic        is_LB_SB,
    input  logic [31:0] alu_result,
    input  logic [31:0] rt_data,
    output logic [7:0]  cache_data_out [0:3],
    output logic [1:0]  mem_block,
    output logic        freeze,
    output logic [31:0] mem_addr,
    output logic        mem_rd_req,
    output logic        mem_wr_req,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int LINES = 2 ** INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag_in;
    logic                  hit;
    logic [3:0]            wstrb_req;
    logic [31:0]           wdata_req;
    logic                  freeze_c;

    assign idx    = alu_result[2 +: INDEX_BITS];
    assign tag_in = alu_result[31 -: TAG_BITS];
    assign hit    = valid_q[idx] && (tag_q[idx] == tag_in);

    assign mem_addr  = {alu_result[31:2], 2'b00};
    assign mem_block = alu_result[1:0];

    // Byte stores put the byte on every lane; the strobe selects the lane.
    assign wstrb_req = is_LB_SB ? (4'b0001 << alu_result[1:0]) : 4'b1111;
    assign wdata_req = is_LB_SB ? {4{rt_data[7:0]}} : rt_data;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            cache_data_out[k] = data_q[idx][8*k +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        freeze_c   = 1'b0;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        mem_wstrb  = 4'b0000;
        mem_wdata  = 32'h0;
        case (state_q)
            IDLE: begin
                if (cache_en) begin
                    if (mem_write) begin
                        freeze_c = 1'b1;
                        state_d  = WRITE;
                    end else if (!hit) begin
                        freeze_c = 1'b1;
                        state_d  = FILL;
                    end
                end
            end
            FILL: begin
                freeze_c   = 1'b1;
                mem_rd_req = 1'b1;
                if (mem_ready) begin
                    state_d = DONE;
                end
            end
            WRITE: begin
                freeze_c   = 1'b1;
                mem_wr_req = 1'b1;
                mem_wstrb  = wstrb_req;
                mem_wdata  = wdata_req;
                if (mem_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The state register resets to IDLE, but an IDLE load miss would still
    // raise freeze while reset is held; gating keeps freeze low in reset.
    assign freeze = rst_b & freeze_c;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid_q <= '0;
        end else if (state_q == FILL && mem_ready) begin
            valid_q[idx] <= 1'b1;
        end
    end

    // Tags and data carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (state_q == FILL && mem_ready) begin
            tag_q[idx]  <= tag_in;
            data_q[idx] <= mem_rdata;
        end else if (state_q == WRITE && mem_ready && hit) begin
            for (int k = 0; k < 4; k++) begin
                if (wstrb_req[k]) begin
                    data_q[idx][8*k +: 8] <= wdata_req[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

    logic        clk;
    logic        rst_b;
    logic        cache_en;
    logic        mem_write;
    logic        is_LB_SB;
    logic [31:0] alu_result;
    logic [31:0] rt_data;
    logic [7:0]  cache_data_out [0:3];
    logic [1:0]  mem_block;
    logic        freeze;
    logic [31:0] mem_addr;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    dcache_ctrl dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .cache_en       (cache_en),
        .mem_write      (mem_write),
        .is_LB_SB       (is_LB_SB),
        .alu_result     (alu_result),
        .rt_data        (rt_data),
        .cache_data_out (cache_data_out),
        .mem_block      (mem_block),
        .freeze         (freeze),
        .mem_addr       (mem_addr),
        .mem_rd_req     (mem_rd_req),
        .mem_wr_req     (mem_wr_req),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_rdata      (mem_rdata),
        .mem_ready      (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        chk;
        logic [31:0] word;
        logic [1:0]  blk;
        int          stalls;
    } resp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rdata;
        int          lat;
    } memx_t;

    resp_t resp_q[$];
    memx_t mem_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: completes each request after its programmed latency
    // and checks the request against the scoreboard entry.
    int mcnt = 0;
    always @(negedge clk) begin
        if (!rst_b) begin
            mcnt = 0;
            mem_ready = 1'b0;
        end else if (mem_rd_req || mem_wr_req) begin
            if (mem_rd_req && mem_wr_req) check("both_req", 32'd1, 32'd0);
            mcnt++;
            if (mem_q.size() == 0) begin
                check("unexpected_req", 32'd1, 32'd0);
                mem_ready = 1'b1;
                mem_rdata = 32'h0;
                mcnt = 0;
            end else if (mcnt >= mem_q[0].lat) begin
                memx_t e;
                e = mem_q.pop_front();
                check("req_is_write", {31'd0, mem_wr_req}, {31'd0, e.wr});
                check("req_addr", mem_addr, e.addr);
                check("req_wstrb", {28'd0, mem_wstrb}, {28'd0, e.strb});
                if (e.wr) check("req_wdata", mem_wdata, e.wdata);
                mem_rdata = e.rdata;
                mem_ready = 1'b1;
                mcnt = 0;
            end else begin
                mem_ready = 1'b0;
            end
        end else begin
            mcnt = 0;
            mem_ready = 1'b0;
        end
    end

    // Response monitor: an access retires on the cycle it is enabled and
    // not frozen; stall cycles before that are counted.
    int stall_cnt = 0;
    always @(negedge clk) begin
        if (!rst_b || !cache_en) begin
            stall_cnt = 0;
        end else if (freeze) begin
            stall_cnt++;
        end else begin
            if (resp_q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                resp_t r;
                r = resp_q.pop_front();
                check("stall_cycles", stall_cnt, r.stalls);
                check("mem_block", {30'd0, mem_block}, {30'd0, r.blk});
                if (r.chk)
                    check("load_data", {cache_data_out[3], cache_data_out[2],
                                        cache_data_out[1], cache_data_out[0]}, r.word);
            end
            stall_cnt = 0;
        end
    end

    task automatic access(input logic wr, input logic bt, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp_word,
                          input int stalls);
        bit done;
        resp_q.push_back('{~wr, exp_word, addr[1:0], stalls});
        @(posedge clk);
        #1;
        cache_en   = 1'b1;
        mem_write  = wr;
        is_LB_SB   = bt;
        alu_result = addr;
        rt_data    = data;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!freeze) done = 1;
        end
        if (!done) check("access_timeout", 32'd1, 32'd0);
    endtask

    task automatic exp_rd(input logic [31:0] addr, input logic [31:0] rdata, input int lat);
        mem_q.push_back('{1'b0, addr, 32'h0, 4'b0000, rdata, lat});
    endtask

    task automatic exp_wr(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int lat);
        mem_q.push_back('{1'b1, addr, wdata, strb, 32'h0, lat});
    endtask

    initial begin
        rst_b      = 1'b0;
        cache_en   = 1'b0;
        mem_write  = 1'b0;
        is_LB_SB   = 1'b0;
        alu_result = 32'h0000_1237;
        rt_data    = 32'h0;
        mem_rdata  = 32'h0;
        mem_ready  = 1'b0;
        #12;
        check("rst_freeze", {31'd0, freeze}, 32'd0);
        check("rst_rd_req", {31'd0, mem_rd_req}, 32'd0);
        check("rst_wr_req", {31'd0, mem_wr_req}, 32'd0);
        check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0000_1234);
        check("rst_mem_block", {30'd0, mem_block}, 32'd3);
        cache_en = 1'b1;
        #1;
        check("rst_freeze_load", {31'd0, freeze}, 32'd0);
        cache_en = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;

        // Cold miss, latency 3: entry cycle + 3
        exp_rd(32'h10, 32'hDEAD_BEEF, 3);
        access(0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 4);
        // Hit: no stall, no memory request
        access(0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0);
        // SB hit at offset 2
        exp_wr(32'h10, 32'h5555_5555, 4'b0100, 2);
        access(1, 1, 32'h12, 32'h0000_0055, 32'h0, 3);
        access(0, 0, 32'h10, 32'h0, 32'hDE55_BEEF, 0);
        // SW miss: written through, not allocated
        exp_wr(32'h30, 32'h1234_5678, 4'b1111, 1);
        access(1, 0, 32'h30, 32'h1234_5678, 32'h0, 2);
        exp_rd(32'h30, 32'h1234_5678, 2);
        access(0, 0, 32'h30, 32'h0, 32'h1234_5678, 3);
        // Conflict: 0x10 and 0x30 share index 4
        exp_rd(32'h10, 32'hDE55_BEEF, 1);
        access(0, 0, 32'h10, 32'h0, 32'hDE55_BEEF, 2);
        exp_rd(32'h30, 32'h1234_5678, 1);
        access(0, 0, 32'h30, 32'h0, 32'h1234_5678, 2);
        // Misaligned SW hit: address forced aligned
        exp_wr(32'h30, 32'h1122_3344, 4'b1111, 1);
        access(1, 0, 32'h32, 32'h1122_3344, 32'h0, 2);
        access(0, 0, 32'h33, 32'h0, 32'h1122_3344, 0);
        // SB with upper garbage in rt_data
        exp_wr(32'h30, 32'hABAB_ABAB, 4'b0010, 1);
        access(1, 1, 32'h31, 32'hFFFF_FFAB, 32'h0, 2);
        access(0, 0, 32'h30, 32'h0, 32'h1122_AB44, 0);

        // Idle cycle: nothing requested
        @(posedge clk);
        #1;
        cache_en  = 1'b0;
        mem_write = 1'b1;
        @(negedge clk);
        check("idle_freeze", {31'd0, freeze}, 32'd0);
        check("idle_wr_req", {31'd0, mem_wr_req}, 32'd0);

        // Reset during FILL
        exp_rd(32'h10, 32'h0, 1000);
        @(posedge clk);
        #1;
        cache_en   = 1'b1;
        mem_write  = 1'b0;
        is_LB_SB   = 1'b0;
        alu_result = 32'h10;
        repeat (3) @(negedge clk);
        check("fill_freeze", {31'd0, freeze}, 32'd1);
        check("fill_rd_req", {31'd0, mem_rd_req}, 32'd1);
        #2;
        rst_b = 1'b0;
        #1;
        check("async_rst_freeze", {31'd0, freeze}, 32'd0);
        check("async_rst_rd_req", {31'd0, mem_rd_req}, 32'd0);
        cache_en = 1'b0;
        mem_q.delete();
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        // All lines invalid after reset
        exp_rd(32'h10, 32'h0BAD_F00D, 2);
        access(0, 0, 32'h10, 32'h0, 32'h0BAD_F00D, 3);
        exp_rd(32'h30, 32'h1122_AB44, 1);
        access(1'b0, 1'b0, 32'h30, 32'h0, 32'h1122_AB44, 2);

        @(posedge clk);
        #1;
        cache_en = 1'b0;
        repeat (2) @(negedge clk);
        check("resp_q_empty", resp_q.size(), 32'd0);
        check("mem_q_empty", mem_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller for the MEM stage.
- Serves the MEM-stage load/store request from the EXE/MEM register.
- Returns a 4-byte line view (cache_data_out) plus a byte offset (mem_block) toward the MEM/WB register.
- Raises freeze to stall every pipeline register while a main-memory transaction is outstanding.

Parameters:
- INDEX_BITS, 3, number of index bits; the cache has 2**INDEX_BITS one-word (4-byte) lines.
- TAG_BITS, 30-INDEX_BITS, tag width taken from addr[31:2+INDEX_BITS].

Ports:
- clk  input  1  pipeline clock, rising-edge.
- rst_b  input  1  asynchronous active-low reset.
- cache_en  input  1  MEM-stage access valid (load or store).
- mem_write  input  1  1 = store, 0 = load; ignored when cache_en=0.
- is_LB_SB  input  1  1 = byte access (LB/SB), 0 = word access (LW/SW).
- alu_result  input  32  effective byte address.
- rt_data  input  32  store data; SB uses rt_data[7:0].
- cache_data_out  output  8 x4 (unpacked [0:3])  line bytes; element k = bits [8k+7:8k] of the stored word.
- mem_block  output  2  alu_result[1:0], passed combinationally.
- freeze  output  1  stall request to all pipeline registers.
- mem_addr  output  32  word-aligned memory address: {alu_result[31:2],2'b00}.
- mem_rd_req  output  1  memory read request.
- mem_wr_req  output  1  memory write request.
- mem_wdata  output  32  memory write data.
- mem_wstrb  output  4  byte enables for the write.
- mem_rdata  input  32  memory read data, valid with mem_ready.
- mem_ready  input  1  one-cycle completion pulse for the current request.

Behaviour:
- Storage: per line, a valid bit, a tag and a 32-bit data word.
  - Reset clears all valid bits only; tags and data are don't-care.
- Hit: valid[idx] && tag[idx]==alu_result[31:2+INDEX_BITS], with idx=alu_result[2+INDEX_BITS-1:2].
- FSM states: IDLE, FILL, WRITE, DONE. Reset -> IDLE.
- IDLE:
  - cache_en=0, or load hit: freeze=0, no memory request.
  - Load hit data is combinational, same cycle: cache_data_out = line[idx].
  - Load miss: freeze=1 combinationally; next state FILL.
  - Store (hit or miss): freeze=1 combinationally; next state WRITE.
- FILL:
  - freeze=1, mem_rd_req=1 held until mem_ready.
  - On mem_ready: line[idx] <= mem_rdata, tag written, valid set; next state DONE.
- WRITE:
  - freeze=1, mem_wr_req=1 held until mem_ready.
  - SW: mem_wstrb=4'b1111, mem_wdata=rt_data.
  - SB: mem_wstrb=1<<alu_result[1:0], and rt_data[7:0] is replicated on all four byte lanes of mem_wdata.
  - On mem_ready, if hit: the enabled bytes of line[idx] are updated the same way (no-write-allocate, so a miss leaves the cache untouched). Next state DONE.
- DONE:
  - freeze=0 for exactly one cycle so the pipeline advances past the held request.
  - The request is not re-evaluated.
  - cache_data_out = line[idx] (just filled, for loads).
  - Next state IDLE.
- Request ordering: mem_rd_req and mem_wr_req are never both 1. Request outputs change only on state transitions.
- Latency:
  - load hit: 0 stall cycles.
  - load miss / store: memory latency + 1 stall cycle (the entry cycle), then DONE.
- mem_ready outside FILL/WRITE is ignored.
- Inputs are held stable by the freeze for the whole transaction; the block does not re-latch them.
- Misaligned word access (alu_result[1:0]!=0 with is_LB_SB=0): address is forced word-aligned, no exception.
- Reset mid-transaction: state returns to IDLE immediately, requests and freeze drop, and all lines are invalid.
- Reset values of all outputs:
  - freeze=0, mem_rd_req=0, mem_wr_req=0, mem_wstrb=0, mem_wdata=0.
  - mem_addr and mem_block follow alu_result.
  - cache_data_out reads an invalid line; its value is don't-care, and the bench checks only valid-qualified data.

Test Plan:
- Reset, then LW 0x0000_0010 with mem_ready 3 cycles after the request and mem_rdata=0xDEADBEEF -> freeze=1 for 4 cycles. DONE cycle gives cache_data_out={EF,BE,AD,DE}, freeze=0.
- Repeat LW 0x10 -> freeze stays 0 and data is available the same cycle; no mem_rd_req.
- SB to 0x12 with rt_data=0x55 (line valid) -> mem_wstrb=4'b0100 and mem_wdata=0x55555555. Following LW 0x10 hits and returns {EF,BE,55,DE}.
- SW to 0x0000_0030 (miss) -> memory write issued. Subsequent LW 0x30 misses (no allocate) and issues mem_rd_req.
- Conflict miss: LW 0x10 then LW 0x30 (INDEX_BITS=3, same index) -> the second access refills the line; LW 0x10 then misses again.
- Assert rst_b=0 during FILL -> freeze and mem_rd_req drop asynchronously. After release, LW 0x10 misses.
